// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEN        = 3'd1,
    ST_DATA       = 3'd2,
    ST_CSUM       = 3'd3,
    ST_FINISH_OK  = 3'd4,
    ST_FINISH_ERR = 3'd5
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // A length byte of zero encodes a full 256-byte image.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/program_loader.sv
// Framed byte-stream writer for the 256x8 instruction store; holds the CPU
// in reset while a program image is being received and checked.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] In_Data,
  input  logic       In_Valid,
  output logic       In_Ready,
  output logic       Mem_We,
  output logic [7:0] Mem_Address,
  output logic [7:0] Mem_Data,
  output logic       Cpu_Hold,
  output logic       Load_Done,
  output logic       Load_Error
);

  state_e     state_q, state_d;
  logic [8:0] count_q, count_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] sum_q, sum_d;
  logic       mem_we_q, mem_we_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_data_q, mem_data_d;
  logic       hold_q, hold_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       in_ready_s;
  logic       accept_s;

  assign in_ready_s = (state_q != ST_FINISH_OK) && (state_q != ST_FINISH_ERR);
  assign accept_s   = In_Valid && in_ready_s;

  // State register and all registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      count_q    <= 9'd0;
      addr_q     <= 8'd0;
      sum_q      <= 8'd0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 8'd0;
      mem_data_q <= 8'd0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      sum_q      <= sum_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Frame parser: next state, write strobe and result pulses.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    sum_d      = sum_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s && (In_Data == SYNC_BYTE)) begin
          state_d = ST_LEN;
          hold_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LEN: begin
        if (accept_s) begin
          count_d = len_to_count(In_Data);
          addr_d  = 8'd0;
          sum_d   = 8'd0;
          state_d = ST_DATA;
        end else begin
          state_d = ST_LEN;
        end
      end

      ST_DATA: begin
        if (accept_s) begin
          mem_we_d   = 1'b1;
          mem_addr_d = addr_q;
          mem_data_d = In_Data;
          sum_d      = csum_add(sum_q, In_Data);
          // Wraps 255->0 only after the final write of a 256-byte frame.
          addr_d     = addr_q + 8'd1;
          count_d    = count_q - 9'd1;
          if (count_q == 9'd1) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_CSUM: begin
        if (accept_s) begin
          if (In_Data == sum_q) begin
            state_d = ST_FINISH_OK;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FINISH_ERR;
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_CSUM;
        end
      end

      ST_FINISH_OK: begin
        hold_d  = 1'b0;
        state_d = ST_IDLE;
      end

      // A failed image keeps the CPU held until a good frame arrives.
      ST_FINISH_ERR: begin
        hold_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign In_Ready    = in_ready_s;
  assign Mem_We      = mem_we_q;
  assign Mem_Address = mem_addr_q;
  assign Mem_Data    = mem_data_q;
  assign Cpu_Hold    = hold_q;
  assign Load_Done   = done_q;
  assign Load_Error  = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus randomized
// frames compared against a stream-level reference model.
module tb_program_loader;

  localparam logic [7:0] SYNC = 8'hA5;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] In_Data = 8'h00;
  logic       In_Valid = 1'b0;
  logic       In_Ready;
  logic       Mem_We;
  logic [7:0] Mem_Address;
  logic [7:0] Mem_Data;
  logic       Cpu_Hold;
  logic       Load_Done;
  logic       Load_Error;

  program_loader dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .In_Data    (In_Data),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Mem_We     (Mem_We),
    .Mem_Address(Mem_Address),
    .Mem_Data   (Mem_Data),
    .Cpu_Hold   (Cpu_Hold),
    .Load_Done  (Load_Done),
    .Load_Error (Load_Error)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [15:0] exp_wr[$];
  logic [7:0]  stim[$];
  logic [7:0]  model_mem[256];
  logic [7:0]  dut_mem[256];
  int   exp_done = 0, exp_err = 0, done_cnt = 0, err_cnt = 0;
  logic exp_hold = 1'b0;
  logic last_ok = 1'b0;
  int   last_len = 0;
  int   wr_cnt = 0, wr_first = 0, wr_last = 0;
  logic [7:0] last_wr_addr = 8'h00;

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every write must match the next one the model predicted.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (Load_Done === 1'b1) done_cnt++;
      if (Load_Error === 1'b1) err_cnt++;
      if (Mem_We === 1'b1) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 32'(Mem_Address), 32'hFFFF_FFFF);
        end else begin
          logic [15:0] e;
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(Mem_Address), 32'(e[15:8]));
          chk("wr_data", 32'(Mem_Data), 32'(e[7:0]));
        end
        dut_mem[Mem_Address] = Mem_Data;
        wr_cnt++;
        if (wr_cnt == 1) wr_first = cyc;
        wr_last = cyc;
        last_wr_addr = Mem_Address;
      end
    end
  end

  // Reference model: parse the whole stream by the frame rules.
  task automatic model_stream();
    int i;
    int len;
    int s;
    i = 0;
    while (i < stim.size()) begin
      if (stim[i] != SYNC) begin
        i++;
      end else begin
        len = (stim[i+1] == 8'h00) ? 256 : int'(stim[i+1]);
        s = 0;
        exp_hold = 1'b1;
        for (int k = 0; k < len; k++) begin
          exp_wr.push_back({8'(k), stim[i+2+k]});
          model_mem[k] = stim[i+2+k];
          s = s + int'(stim[i+2+k]);
        end
        last_ok  = (stim[i+2+len] == 8'(s % 256));
        last_len = len;
        if (last_ok) begin
          exp_done++;
          exp_hold = 1'b0;
        end else begin
          exp_err++;
        end
        i = i + len + 3;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int g;
    int t;
    g = 0;
    while (g < 8 && $urandom_range(0, 99) < gap_pct) begin
      In_Valid = 1'b0;
      In_Data  = 8'($urandom);
      @(posedge Clk); #1;
      g++;
    end
    In_Data  = b;
    In_Valid = 1'b1;
    t = 0;
    while (In_Ready !== 1'b1 && t < 16) begin
      @(posedge Clk); #1;
      t++;
    end
    if (t >= 16) chk("ready_timeout", 32'(In_Ready), 32'd1);
    @(posedge Clk); #1;
    In_Valid = 1'b0;
  endtask

  task automatic run_stream(input int gap_pct, input bit consec);
    int bad;
    model_stream();
    wr_cnt = 0;
    for (int i = 0; i < stim.size(); i++) send_byte(stim[i], gap_pct);
    chk("done_pulse", 32'(Load_Done), 32'(last_ok));
    chk("err_pulse", 32'(Load_Error), 32'(!last_ok));
    chk("ready_in_finish", 32'(In_Ready), 32'd0);
    chk("hold_in_finish", 32'(Cpu_Hold), 32'd1);
    @(posedge Clk); #1;
    chk("done_cleared", 32'(Load_Done), 32'd0);
    chk("err_cleared", 32'(Load_Error), 32'd0);
    chk("ready_after", 32'(In_Ready), 32'd1);
    chk("hold_after", 32'(Cpu_Hold), 32'(exp_hold));
    repeat (2) @(posedge Clk);
    #1;
    chk("writes_pending", 32'(exp_wr.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(exp_done));
    chk("err_count", 32'(err_cnt), 32'(exp_err));
    bad = 0;
    for (int a = 0; a < 256; a++) if (dut_mem[a] !== model_mem[a]) bad++;
    chk("mem_readback", 32'(bad), 32'd0);
    if (consec) begin
      chk("write_count", 32'(wr_cnt), 32'(last_len));
      chk("writes_consecutive", 32'(wr_last - wr_first), 32'(last_len - 1));
    end
  endtask

  initial begin
    logic [7:0] b;
    int len;
    int s;
    for (int a = 0; a < 256; a++) begin
      model_mem[a] = 8'h00;
      dut_mem[a]   = 8'h00;
    end

    // Reset state
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_mem_we", 32'(Mem_We), 32'd0);
    chk("rst_mem_addr", 32'(Mem_Address), 32'd0);
    chk("rst_mem_data", 32'(Mem_Data), 32'd0);
    chk("rst_hold", 32'(Cpu_Hold), 32'd0);
    chk("rst_done", 32'(Load_Done), 32'd0);
    chk("rst_err", 32'(Load_Error), 32'd0);
    chk("rst_ready", 32'(In_Ready), 32'd1);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Basic load
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    run_stream(0, 1'b1);

    // Full 256-byte frame
    stim.delete();
    stim.push_back(8'hA5);
    stim.push_back(8'h00);
    for (int i = 0; i < 256; i++) stim.push_back(8'(i));
    stim.push_back(8'h80);
    run_stream(0, 1'b1);
    chk("full_last_addr", 32'(last_wr_addr), 32'hFF);
    chk("full_last_ok", 32'(last_ok), 32'd1);

    // Bad checksum, then a good frame clears the hold
    stim = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h04};
    run_stream(0, 1'b1);
    stim = '{8'hA5, 8'h01, 8'h7E, 8'h7E};
    run_stream(0, 1'b1);

    // Garbage before sync, sync value inside payload
    stim = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'hA5, 8'hA5};
    run_stream(0, 1'b1);

    // Valid gaps
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    run_stream(50, 1'b0);

    // Reset mid-frame after two data bytes
    exp_wr.push_back({8'h00, 8'h12});
    exp_wr.push_back({8'h01, 8'h34});
    model_mem[0] = 8'h12;
    model_mem[1] = 8'h34;
    send_byte(8'hA5, 0);
    send_byte(8'h04, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    @(negedge Clk);
    chk("hold_mid_frame", 32'(Cpu_Hold), 32'd1);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;
    chk("midrst_hold", 32'(Cpu_Hold), 32'd0);
    chk("midrst_we", 32'(Mem_We), 32'd0);
    chk("midrst_ready", 32'(In_Ready), 32'd1);
    chk("midrst_writes", 32'(exp_wr.size()), 32'd0);
    Reset = 1'b0;
    exp_hold = 1'b0;
    @(posedge Clk); #1;
    stim = '{8'hA5, 8'h02, 8'h40, 8'h02, 8'h42};
    run_stream(0, 1'b1);

    // Randomized frames with garbage prefixes, gaps and corrupted checksums
    for (int f = 0; f < 8; f++) begin
      stim.delete();
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        stim.push_back(b);
      end
      len = int'($urandom_range(1, 24));
      stim.push_back(SYNC);
      stim.push_back(8'(len));
      s = 0;
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom);
        stim.push_back(b);
        s = s + int'(b);
      end
      if ($urandom_range(0, 99) < 30) stim.push_back(8'(s) ^ 8'($urandom_range(1, 255)));
      else stim.push_back(8'(s));
      run_stream(40, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
